program_loader_sequencer: RTL and testbench

//   Sequences power-up and reload of the 16x8 program RAM, then releases the CPU.
//   - Accepts program bytes over a valid/ready stream and writes them to consecutive RAM addresses.
//   - Holds the CPU controller/ring counter in reset (cpu_clr) during the load and for a full
//     T1..T6 ring period after it, then lets the CPU run from address 0.
//   - Sits between the front-panel/host loader and the RAM write port + CPU CLR net.

---
 rtl/program_loader_sequencer.sv | 140 ++++++++++++++
 tb/tb_program_loader_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_sequencer.sv
// Loads program bytes from a valid/ready stream into consecutive RAM words while holding the CPU in
// reset, keeps it held for one full ring period after the final write, then releases it.
module program_loader_sequencer #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned RELEASE_CYC = 6
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              load_req,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              cpu_clr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_HOLD = 2'd2,
      S_RUN  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     wp_q, wp_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_ready_q, wr_ready_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_data_q, ram_data_d;
   logic                cpu_clr_q, cpu_clr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                accept_c;
   logic                final_c;

   assign accept_c = wr_valid & wr_ready_q & (state_q == S_LOAD);
   // Load ends on an explicit last byte or when the final RAM word is taken; the pointer never wraps.
   assign final_c  = accept_c & (wr_last | (wp_q == (ADDR_W+1)'(DEPTH - 1)));

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (load_req) state_d = S_LOAD;
         S_LOAD: if (final_c)  state_d = S_HOLD;
         S_HOLD: begin
            if (load_req)                                   state_d = S_LOAD;
            else if (cnt_q == CNT_W'(RELEASE_CYC - 1))      state_d = S_RUN;
         end
         S_RUN:  if (load_req) state_d = S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wp_d       = wp_q;
      cnt_d      = '0;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      words_d    = words_q;

      if (state_d == S_LOAD && state_q != S_LOAD) begin
         wp_d = '0;
      end
      if (state_q == S_HOLD && state_d == S_HOLD) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // Write strobe lags the accepting edge by one cycle.
      if (accept_c) begin
         ram_we_d   = 1'b1;
         ram_addr_d = wp_q[ADDR_W-1:0];
         ram_data_d = wr_data;
         wp_d       = wp_q + (ADDR_W+1)'(1);
      end
      if (final_c) begin
         words_d = wp_q + (ADDR_W+1)'(1);
      end

      wr_ready_d = (state_d == S_LOAD);
      busy_d     = (state_d == S_LOAD) || (state_d == S_HOLD);
      done_d     = (state_d == S_RUN);
      cpu_clr_d  = (state_d != S_RUN);
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         wp_q       <= '0;
         cnt_q      <= '0;
         wr_ready_q <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_data_q <= '0;
         cpu_clr_q  <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         words_q    <= '0;
      end else begin
         wp_q       <= wp_d;
         cnt_q      <= cnt_d;
         wr_ready_q <= wr_ready_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_data_q <= ram_data_d;
         cpu_clr_q  <= cpu_clr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         words_q    <= words_d;
      end
   end

   assign wr_ready = wr_ready_q;
   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign cpu_clr  = cpu_clr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign words    = words_q;

endmodule

// File: tb/tb_program_loader_sequencer.sv
// Scoreboard bench for program_loader_sequencer: expected RAM writes are queued as bytes are
// accepted and checked against each ram_we strobe; release timing and status checked per load.
module tb_program_loader_sequencer;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   logic              CLK = 1'b0;
   logic              CLR;
   logic              load_req;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic              wr_ready;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              cpu_clr;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   words;

   int n_vec = 0;
   int n_err = 0;
   int tb_wp = 0;
   logic [ADDR_W+DATA_W-1:0] exp_q [$];
   logic [ADDR_W+DATA_W-1:0] mon_e;

   program_loader_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_CYC(6)) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .load_req (load_req),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_last  (wr_last),
      .wr_ready (wr_ready),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .cpu_clr  (cpu_clr),
      .busy     (busy),
      .done     (done),
      .words    (words)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Every strobe must match the oldest outstanding accepted byte.
   always @(negedge CLK) begin
      if (ram_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_we", 32'(1), 32'(0));
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
            chk("wr_data", 32'(ram_data), 32'(mon_e[DATA_W-1:0]));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      tb_wp    = 0;
      chk("ld_ready", 32'(wr_ready), 32'(1));
      chk("ld_cpu_clr", 32'(cpu_clr), 32'(1));
      chk("ld_done", 32'(done), 32'(0));
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      int w;
      w = 0;
      while (!wr_ready && w < 50) begin
         tick();
         w++;
      end
      if (!wr_ready) begin
         chk("ready_timeout", 32'(0), 32'(1));
         return;
      end
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = last;
      exp_q.push_back({ADDR_W'(tb_wp), d});
      tb_wp++;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   // Called in the first HOLD cycle; junk on wr_valid must be ignored while held.
   task automatic release_chk(input int exp_words);
      int n;
      chk("hold_busy", 32'(busy), 32'(1));
      chk("hold_ready", 32'(wr_ready), 32'(0));
      wr_valid = 1'b1;
      wr_data  = 8'hEE;
      for (n = 1; n <= 20; n++) begin
         tick();
         if (!cpu_clr) break;
      end
      wr_valid = 1'b0;
      chk("release_lat", 32'(n), 32'(6));
      chk("words", 32'(words), 32'(exp_words));
      chk("run_done", 32'(done), 32'(1));
      chk("run_busy", 32'(busy), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      CLR      = 1'b1;
      load_req = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      wr_last  = 1'b0;

      // Reset and idle
      tick();
      tick();
      chk("rst_cpu_clr", 32'(cpu_clr), 32'(1));
      chk("rst_words", 32'(words), 32'(0));
      chk("rst_addr", 32'(ram_addr), 32'(0));
      chk("rst_data", 32'(ram_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      CLR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_cpu_clr", 32'(cpu_clr), 32'(1));
         chk("idle_we", 32'(ram_we), 32'(0));
         chk("idle_ready", 32'(wr_ready), 32'(0));
         chk("idle_done", 32'(done), 32'(0));
      end

      // Full 16-byte load ends on depth, no wr_last
      pulse_load();
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      chk("full_we_h0", 32'(ram_we), 32'(1));
      release_chk(16);

      // Three bytes with wr_last; also checks re-entry from RUN
      pulse_load();
      send(8'h09, 1'b0);
      send(8'h1A, 1'b0);
      send(8'h2B, 1'b1);
      release_chk(3);

      // Stalling loader
      pulse_load();
      send(8'h31, 1'b0);
      tick();
      tick();
      send(8'h42, 1'b0);
      tick();
      send(8'h53, 1'b0);
      tick();
      tick();
      send(8'h64, 1'b1);
      release_chk(4);

      // Reload from RUN with two bytes
      pulse_load();
      send(8'hA5, 1'b0);
      send(8'h5A, 1'b1);
      release_chk(2);

      // Abort mid-load with CLR; the sixth byte is never written
      pulse_load();
      for (int i = 0; i < 5; i++) send(8'(8'h70 + i), 1'b0);
      CLR      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h99;
      tick();
      CLR = 1'b0;
      chk("abort_we", 32'(ram_we), 32'(0));
      chk("abort_ready", 32'(wr_ready), 32'(0));
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_cpu_clr", 32'(cpu_clr), 32'(1));
      chk("abort_words", 32'(words), 32'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_idle_we", 32'(ram_we), 32'(0));
      end
      wr_valid = 1'b0;
      pulse_load();
      send(8'hC3, 1'b0);
      send(8'h3C, 1'b1);
      release_chk(2);

      tick();
      chk("sb_empty", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
